gfx_bus_master: RTL and testbench

Bus initiator for the Graphics ASIC register port; it drives `chipselect`, `read`, `data_address` and the 16-bit data bus so game logic can update graphics registers (paddle, ball, score positions). It accepts read and write commands on a valid/ready interface and buffers them in a small FIFO. It issues them to the ASIC only while the ASIC is not fetching active video, and returns read data on a one-cycle response strobe. It sits in `top` between the game-logic block and `Graphics_ASIC`. The tri-state data bus is resolved in `top` from `bus_wdata`/`bus_oe`.

---
 rtl/gfx_pkg.sv | 42 ++++
 rtl/gfx_cmd_fifo.sv | 55 +++++
 rtl/gfx_bus_master.sv | 121 ++++++++++++
 tb/tb_gfx_bus_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the Graphics ASIC bus master: command record layout,
// FSM state encoding and the register map of the Graphics ASIC.
package gfx_pkg;

    localparam int GFX_ADDR_W = 4;
    localparam int GFX_DATA_W = 16;
    localparam int GFX_CMD_W  = 1 + GFX_ADDR_W + GFX_DATA_W;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_SETUP = 3'd1;
    localparam logic [2:0] ST_WR_HOLD  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_TURN     = 3'd4;

    // Graphics ASIC register addresses
    localparam logic [GFX_ADDR_W-1:0] GFX_REG_PADDLE_L_Y = 4'h0;
    localparam logic [GFX_ADDR_W-1:0] GFX_REG_PADDLE_R_Y = 4'h1;
    localparam logic [GFX_ADDR_W-1:0] GFX_REG_BALL_X     = 4'h2;
    localparam logic [GFX_ADDR_W-1:0] GFX_REG_BALL_Y     = 4'h3;
    localparam logic [GFX_ADDR_W-1:0] GFX_REG_SCORE_L    = 4'h4;
    localparam logic [GFX_ADDR_W-1:0] GFX_REG_SCORE_R    = 4'h5;
    localparam logic [GFX_ADDR_W-1:0] GFX_REG_STATUS     = 4'h6;

    // One queued bus command; write flag in the MSB
    typedef struct packed {
        logic                  write;
        logic [GFX_ADDR_W-1:0] addr;
        logic [GFX_DATA_W-1:0] wdata;
    } gfx_cmd_t;

    function automatic gfx_cmd_t pack_cmd(input logic write,
                                          input logic [GFX_ADDR_W-1:0] addr,
                                          input logic [GFX_DATA_W-1:0] wdata);
        gfx_cmd_t c;
        c.write = write;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous command FIFO with a first-word-fall-through head. Pointers carry
// one extra wrap bit so full and empty can be told apart when the indices match.
module gfx_cmd_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = GFX_CMD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since the pointers guard reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointer update; push and pop may happen in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfx_bus_master.sv
// Bus initiator for the Graphics ASIC register port. Queues read/write
// commands and plays them onto the chipselect/read/address/data bus only
// while the ASIC is outside its active-video fetch.
module gfx_bus_master
    import gfx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [GFX_ADDR_W-1:0] cmd_addr,
    input  logic [GFX_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [GFX_DATA_W-1:0] rsp_rdata,
    input  logic                  vga_ready,
    output logic                  chipselect,
    output logic                  read,
    output logic [GFX_ADDR_W-1:0] data_address,
    output logic [GFX_DATA_W-1:0] bus_wdata,
    output logic                  bus_oe,
    input  logic [GFX_DATA_W-1:0] bus_rdata,
    output logic                  busy
);

    logic [2:0] state;
    logic [2:0] rd_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       launch;
    gfx_cmd_t   head;

    // A new transaction may start from IDLE or straight out of the turnaround
    // cycle, which keeps chipselect low for only one cycle between commands.
    assign launch    = ((state == ST_IDLE) || (state == ST_TURN)) && !fifo_empty && !vga_ready;
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    gfx_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (GFX_CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (pack_cmd(cmd_write, cmd_addr, cmd_wdata)),
        .pop   (launch),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus FSM with registered strobes, address/data and read response
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rd_cnt       <= 3'd0;
            chipselect   <= 1'b0;
            read         <= 1'b0;
            bus_oe       <= 1'b0;
            data_address <= '0;
            bus_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_TURN: begin
                    chipselect <= 1'b0;
                    read       <= 1'b0;
                    bus_oe     <= 1'b0;
                    state      <= ST_IDLE;
                    if (launch) begin
                        chipselect   <= 1'b1;
                        data_address <= head.addr;
                        if (head.write) begin
                            bus_wdata <= head.wdata;
                            bus_oe    <= 1'b1;
                            state     <= ST_WR_SETUP;
                        end else begin
                            read   <= 1'b1;
                            rd_cnt <= 3'(RD_LAT - 1);
                            state  <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WR_SETUP: begin
                    state <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    chipselect <= 1'b0;
                    bus_oe     <= 1'b0;
                    state      <= ST_TURN;
                end
                ST_RD_WAIT: begin
                    if (rd_cnt == 3'd0) begin
                        rsp_rdata  <= bus_rdata;
                        rsp_valid  <= 1'b1;
                        chipselect <= 1'b0;
                        read       <= 1'b0;
                        state      <= ST_TURN;
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end
                default: begin
                    chipselect <= 1'b0;
                    read       <= 1'b0;
                    bus_oe     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_bus_master.sv
// Directed testbench for gfx_bus_master: single write/read timing, video
// gating, full FIFO back-pressure, push/pop streaming and mid-read reset.
module tb_gfx_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        vga_ready;
    logic        chipselect;
    logic        read;
    logic [3:0]  data_address;
    logic [15:0] bus_wdata;
    logic        bus_oe;
    logic [15:0] bus_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gfx_bus_master #(
        .DEPTH  (4),
        .RD_LAT (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .vga_ready    (vga_ready),
        .chipselect   (chipselect),
        .read         (read),
        .data_address (data_address),
        .bus_wdata    (bus_wdata),
        .bus_oe       (bus_oe),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    // Advance one clock and sample just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for a single edge
    task automatic push_cmd(input logic w, input logic [3:0] a, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 16'h0;
        vga_ready = 1'b0;
        bus_rdata = 16'h0;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if ({chipselect, read, bus_oe, rsp_valid, busy} !== 5'b00000) begin
            n_err++; $display("[TB] FAIL reset_strobes: got %b expected 00000", {chipselect, read, bus_oe, rsp_valid, busy});
        end
        n_cmp++; if (cmd_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        n_cmp++; if (data_address !== 4'h0) begin
            n_err++; $display("[TB] FAIL reset_addr: got %h expected 0", data_address);
        end
        n_cmp++; if (bus_wdata !== 16'h0) begin
            n_err++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus_wdata);
        end
        n_cmp++; if (rsp_rdata !== 16'h0) begin
            n_err++; $display("[TB] FAIL reset_rdata: got %h expected 0", rsp_rdata);
        end
    endtask

    task automatic test_single_write();
        logic [4:0] exp_cs;
        exp_cs = 5'b00110;
        push_cmd(1'b1, 4'h3, 16'hBEEF);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_cmp++; if (chipselect !== exp_cs[i]) begin
                n_err++; $display("[TB] FAIL wr_cs[%0d]: got %b expected %b", i, chipselect, exp_cs[i]);
            end
            n_cmp++; if (bus_oe !== exp_cs[i] || read !== 1'b0) begin
                n_err++; $display("[TB] FAIL wr_oe_read[%0d]: got oe=%b read=%b expected oe=%b read=0", i, bus_oe, read, exp_cs[i]);
            end
            if (exp_cs[i]) begin
                n_cmp++; if (data_address !== 4'h3 || bus_wdata !== 16'hBEEF) begin
                    n_err++; $display("[TB] FAIL wr_addr_data[%0d]: got %h/%h expected 3/beef", i, data_address, bus_wdata);
                end
            end
            n_cmp++; if (busy !== (i < 4)) begin
                n_err++; $display("[TB] FAIL wr_busy[%0d]: got %b expected %b", i, busy, (i < 4));
            end
        end
    endtask

    task automatic test_read();
        logic [4:0] exp_rd;
        logic [4:0] exp_rv;
        exp_rd = 5'b00110;
        exp_rv = 5'b01000;
        bus_rdata = 16'h1234;
        push_cmd(1'b0, 4'h5, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_cmp++; if (read !== exp_rd[i] || chipselect !== exp_rd[i]) begin
                n_err++; $display("[TB] FAIL rd_strobe[%0d]: got cs=%b read=%b expected %b", i, chipselect, read, exp_rd[i]);
            end
            n_cmp++; if (bus_oe !== 1'b0) begin
                n_err++; $display("[TB] FAIL rd_oe[%0d]: got %b expected 0", i, bus_oe);
            end
            if (exp_rd[i]) begin
                n_cmp++; if (data_address !== 4'h5) begin
                    n_err++; $display("[TB] FAIL rd_addr[%0d]: got %h expected 5", i, data_address);
                end
            end
            n_cmp++; if (rsp_valid !== exp_rv[i]) begin
                n_err++; $display("[TB] FAIL rd_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, exp_rv[i]);
            end
            if (i >= 3) begin
                n_cmp++; if (rsp_rdata !== 16'h1234) begin
                    n_err++; $display("[TB] FAIL rd_rdata[%0d]: got %h expected 1234", i, rsp_rdata);
                end
            end
        end
        bus_rdata = 16'h0;
    endtask

    task automatic test_gating();
        logic [9:0] exp_cs;
        int         cs_seen;
        int         waited;
        exp_cs    = 10'b0011011011;
        vga_ready = 1'b1;
        push_cmd(1'b1, 4'h1, 16'hA001);
        push_cmd(1'b1, 4'h2, 16'hA002);
        push_cmd(1'b1, 4'h3, 16'hA003);
        cs_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (chipselect) cs_seen++;
        end
        n_cmp++; if (cs_seen !== 0) begin
            n_err++; $display("[TB] FAIL gate_hold: got %0d cs cycles expected 0", cs_seen);
        end
        vga_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++; if (chipselect !== exp_cs[i-1]) begin
                n_err++; $display("[TB] FAIL gate_cs[%0d]: got %b expected %b", i, chipselect, exp_cs[i-1]);
            end
            if (i == 1 || i == 4 || i == 7) begin
                n_cmp++; if (data_address !== 4'((i - 1) / 3 + 1) || bus_wdata !== 16'(16'hA000 + (i - 1) / 3 + 1)) begin
                    n_err++; $display("[TB] FAIL gate_order[%0d]: got %h/%h expected %0d/%h", i, data_address, bus_wdata, (i - 1) / 3 + 1, 16'(16'hA000 + (i - 1) / 3 + 1));
                end
            end
            n_cmp++; if (busy !== (i <= 9)) begin
                n_err++; $display("[TB] FAIL gate_busy[%0d]: got %b expected %b", i, busy, (i <= 9));
            end
        end
        // raise the gate during the first write; the second must wait
        vga_ready = 1'b1;
        push_cmd(1'b1, 4'hA, 16'h1111);
        push_cmd(1'b1, 4'hB, 16'h2222);
        vga_ready = 1'b0;
        step();
        vga_ready = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            step();
            n_cmp++; if (chipselect !== (i == 2)) begin
                n_err++; $display("[TB] FAIL gate_mid_cs[%0d]: got %b expected %b", i, chipselect, (i == 2));
            end
        end
        n_cmp++; if (busy !== 1'b1) begin
            n_err++; $display("[TB] FAIL gate_mid_busy: got %b expected 1", busy);
        end
        vga_ready = 1'b0;
        waited = 0;
        while (!chipselect && waited < 10) begin
            step();
            waited++;
        end
        n_cmp++; if (chipselect !== 1'b1 || data_address !== 4'hB || bus_wdata !== 16'h2222) begin
            n_err++; $display("[TB] FAIL gate_resume: got cs=%b %h/%h expected cs=1 b/2222", chipselect, data_address, bus_wdata);
        end
        waited = 0;
        while (busy && waited < 10) begin
            step();
            waited++;
        end
        n_cmp++; if (busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL gate_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_full_fifo();
        logic [3:0]  seen_addr [8];
        logic [15:0] seen_data [8];
        int          n_tx;
        logic        prev_cs;
        logic        accepted;
        vga_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b1, 4'(4 + i), 16'(16'hC004 + i));
        end
        n_cmp++; if (cmd_ready !== 1'b0) begin
            n_err++; $display("[TB] FAIL full_ready: got %b expected 0", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'h8;
        cmd_wdata = 16'hC008;
        step();
        step();
        n_cmp++; if (cmd_ready !== 1'b0 || chipselect !== 1'b0) begin
            n_err++; $display("[TB] FAIL full_hold: got ready=%b cs=%b expected 0/0", cmd_ready, chipselect);
        end
        vga_ready = 1'b0;
        n_tx      = 0;
        prev_cs   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            accepted = cmd_valid && cmd_ready;
            step();
            if (accepted) cmd_valid = 1'b0;
            if (chipselect && !prev_cs) begin
                if (n_tx < 8) begin
                    seen_addr[n_tx] = data_address;
                    seen_data[n_tx] = bus_wdata;
                end
                n_tx++;
            end
            prev_cs = chipselect;
            if (!busy && !cmd_valid) break;
        end
        n_cmp++; if (n_tx !== 5) begin
            n_err++; $display("[TB] FAIL full_tx_count: got %0d expected 5", n_tx);
        end
        for (int i = 0; i < 5 && i < n_tx; i++) begin
            n_cmp++; if (seen_addr[i] !== 4'(4 + i) || seen_data[i] !== 16'(16'hC004 + i)) begin
                n_err++; $display("[TB] FAIL full_order[%0d]: got %h/%h expected %h/%h", i, seen_addr[i], seen_data[i], 4'(4 + i), 16'(16'hC004 + i));
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_push_pop();
        logic        cw [20];
        logic [3:0]  ca [20];
        logic [15:0] cd [20];
        int          sent;
        int          got;
        int          n_rd;
        int          n_rsp;
        logic        prev_cs;
        logic        pushing;
        n_rd = 0;
        for (int i = 0; i < 20; i++) begin
            cw[i] = 1'($urandom_range(0, 1));
            ca[i] = 4'($urandom_range(0, 15));
            cd[i] = 16'($urandom);
            if (!cw[i]) n_rd++;
        end
        vga_ready = 1'b0;
        bus_rdata = 16'h5A5A;
        sent      = 0;
        got       = 0;
        n_rsp     = 0;
        prev_cs   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = cw[0];
        cmd_addr  = ca[0];
        cmd_wdata = cd[0];
        for (int c = 0; c < 400; c++) begin
            pushing = cmd_valid;
            if (pushing) begin
                n_cmp++; if (cmd_ready !== 1'b1) begin
                    n_err++; $display("[TB] FAIL pp_ready[%0d]: got %b expected 1", sent, cmd_ready);
                end
            end
            step();
            if (pushing) begin
                cmd_valid = 1'b0;
                sent++;
            end
            if (chipselect && !prev_cs) begin
                if (got >= 20) begin
                    n_cmp++; n_err++;
                    $display("[TB] FAIL pp_extra: got transaction %0d expected at most 20", got + 1);
                end else begin
                    n_cmp++; if (data_address !== ca[got] || read !== !cw[got] || (cw[got] && bus_wdata !== cd[got])) begin
                        n_err++; $display("[TB] FAIL pp_tx[%0d]: got rd=%b %h/%h expected rd=%b %h/%h", got, read, data_address, bus_wdata, !cw[got], ca[got], cd[got]);
                    end
                end
                got++;
            end
            if (rsp_valid) begin
                n_rsp++;
                n_cmp++; if (rsp_rdata !== 16'h5A5A) begin
                    n_err++; $display("[TB] FAIL pp_rdata: got %h expected 5a5a", rsp_rdata);
                end
            end
            if (sent < 20 && !cmd_valid && ((sent == 1 && got == 0) || (!chipselect && prev_cs))) begin
                cmd_valid = 1'b1;
                cmd_write = cw[sent];
                cmd_addr  = ca[sent];
                cmd_wdata = cd[sent];
            end
            prev_cs = chipselect;
            if (got >= 20 && !busy && !cmd_valid) break;
        end
        cmd_valid = 1'b0;
        n_cmp++; if (got !== 20) begin
            n_err++; $display("[TB] FAIL pp_count: got %0d expected 20", got);
        end
        n_cmp++; if (n_rsp !== n_rd) begin
            n_err++; $display("[TB] FAIL pp_rsp_count: got %0d expected %0d", n_rsp, n_rd);
        end
    endtask

    task automatic test_reset_mid();
        int cs_seen;
        int rv_seen;
        vga_ready = 1'b1;
        bus_rdata = 16'hFFFF;
        push_cmd(1'b0, 4'h9, 16'h0000);
        push_cmd(1'b1, 4'hC, 16'h3333);
        push_cmd(1'b1, 4'hD, 16'h4444);
        vga_ready = 1'b0;
        step();
        step();
        n_cmp++; if (read !== 1'b1 || data_address !== 4'h9) begin
            n_err++; $display("[TB] FAIL rst_mid_pre: got read=%b addr=%h expected 1/9", read, data_address);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({chipselect, read, bus_oe, rsp_valid} !== 4'b0000) begin
            n_err++; $display("[TB] FAIL rst_mid_strobes: got %b expected 0000", {chipselect, read, bus_oe, rsp_valid});
        end
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL rst_mid_flags: got ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
        cs_seen = 0;
        rv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (chipselect) cs_seen++;
            if (rsp_valid) rv_seen++;
        end
        n_cmp++; if (cs_seen !== 0 || rv_seen !== 0) begin
            n_err++; $display("[TB] FAIL rst_mid_quiet: got cs=%0d rsp=%0d expected 0/0", cs_seen, rv_seen);
        end
        n_cmp++; if (rsp_rdata !== 16'h0) begin
            n_err++; $display("[TB] FAIL rst_mid_rdata: got %h expected 0", rsp_rdata);
        end
    endtask

    // Runs every scenario in order and prints the summary
    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_gating();
        test_full_fifo();
        test_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guards against a stuck simulation
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
